// File: rtl/mem_port_arbiter_if.sv
// Request/grant bus between the three memory requesters, the arbiter and the
// single-ported unified memory macro.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Requester side: port 0 = debug/loader, 1 = data load/store, 2 = fetch
    logic [2:0]        req;
    logic [2:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] wdata2;
    logic [2:0]        gnt;
    logic [2:0]        done;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    // Memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
        output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
        input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-port arbiter for the single-ported unified memory: one transaction in
// flight, fields latched at grant, all outputs registered.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] PORT_DBG   = 2'd0;
    localparam logic [1:0] PORT_DATA  = 2'd1;
    localparam logic [1:0] PORT_FETCH = 2'd2;

    state_t            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              we_q, we_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        rr_last_q, rr_last_d;
    logic              dbg_hold_q, dbg_hold_d;

    logic [2:0]        gnt_q, gnt_d;
    logic [2:0]        done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [1:0]        win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    function automatic logic [2:0] port_bit(input logic [1:0] p);
        return 3'(3'b001 << p);
    endfunction

    // Debug wins unless it was granted last and the CPU is waiting;
    // data and fetch alternate on a tie.
    always_comb begin
        win = PORT_FETCH;
        if (bus.req[0] && !(dbg_hold_q && (bus.req[1] || bus.req[2]))) begin
            win = PORT_DBG;
        end else if (bus.req[1] && bus.req[2]) begin
            win = (rr_last_q == PORT_DATA) ? PORT_FETCH : PORT_DATA;
        end else if (bus.req[1]) begin
            win = PORT_DATA;
        end
    end

    always_comb begin
        case (win)
            PORT_DBG: begin
                sel_we    = bus.we[0];
                sel_addr  = bus.addr0;
                sel_wdata = bus.wdata0;
            end
            PORT_DATA: begin
                sel_we    = bus.we[1];
                sel_addr  = bus.addr1;
                sel_wdata = bus.wdata1;
            end
            default: begin
                sel_we    = bus.we[2];
                sel_addr  = bus.addr2;
                sel_wdata = bus.wdata2;
            end
        endcase
    end

    always_comb begin
        // NOTE: every target gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        rr_last_d   = rr_last_q;
        dbg_hold_d  = dbg_hold_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        gnt_d       = 3'b000;
        done_d      = 3'b000;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d     = ISSUE;
                    owner_d     = win;
                    we_d        = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    gnt_d       = port_bit(win);
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_we;
                    if (win == PORT_DBG) begin
                        dbg_hold_d = 1'b1;
                    end else begin
                        dbg_hold_d = 1'b0;
                        rr_last_d  = win;
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                    done_d  = port_bit(owner_q);
                end else begin
                    state_d = WAIT;
                    cnt_d   = 3'(MEM_LAT);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Counter reaches 1 exactly MEM_LAT cycles after the strobe
                if (cnt_q == 3'd1) begin
                    state_d = DONE;
                    rdata_d = bus.mem_rdata;
                    done_d  = port_bit(owner_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q     <= IDLE;
            owner_q     <= PORT_DBG;
            we_q        <= 1'b0;
            cnt_q       <= 3'd0;
            rr_last_q   <= PORT_DATA;
            dbg_hold_q  <= 1'b0;
            gnt_q       <= 3'b000;
            done_q      <= 3'b000;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            rr_last_q   <= rr_last_d;
            dbg_hold_q  <= dbg_hold_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Handshake invariants seen by the requesters
    a_gnt_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(done_q));
    a_gnt_pulse:   assert property (@(posedge clk) disable iff (rst) (gnt_q != 3'b000) |=> (gnt_q == 3'b000));
    a_done_state:  assert property (@(posedge clk) disable iff (rst) (done_q != 3'b000) |-> (state_q == DONE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 7) share
// the requester stimulus; the MEM_LAT=2 instance is fully scoreboarded.
module tb_mem_port_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT0 = 2;
  localparam int LAT1 = 1;
  localparam int LAT2 = 7;

  typedef struct packed {
    logic [2:0]  port;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [15:0] addr [3];
  logic [15:0] wdata [3];
  logic [15:0] model_rdata;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  logic [15:0] mem_w [logic [15:0]];
  logic [15:0] pipe0 [8];
  logic [15:0] pipe1 [8];
  logic [15:0] pipe2 [8];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  assign {bus0.req, bus0.we} = {req, we};
  assign {bus0.addr0, bus0.addr1, bus0.addr2} = {addr[0], addr[1], addr[2]};
  assign {bus0.wdata0, bus0.wdata1, bus0.wdata2} = {wdata[0], wdata[1], wdata[2]};
  assign bus0.mem_rdata = pipe0[LAT0-1];
  assign {bus1.req, bus1.we} = {req, we};
  assign {bus1.addr0, bus1.addr1, bus1.addr2} = {addr[0], addr[1], addr[2]};
  assign {bus1.wdata0, bus1.wdata1, bus1.wdata2} = {wdata[0], wdata[1], wdata[2]};
  assign bus1.mem_rdata = pipe1[LAT1-1];
  assign {bus2.req, bus2.we} = {req, we};
  assign {bus2.addr0, bus2.addr1, bus2.addr2} = {addr[0], addr[1], addr[2]};
  assign {bus2.wdata0, bus2.wdata1, bus2.wdata2} = {wdata[0], wdata[1], wdata[2]};
  assign bus2.mem_rdata = pipe2[LAT2-1];

  // Memory contents: written locations, else a fixed address pattern
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem_w.exists(a)) return mem_w[a];
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hA5C3);
  endfunction

  function automatic int port_of(input logic [2:0] oh);
    return oh[0] ? 0 : (oh[1] ? 1 : 2);
  endfunction

  // Memory macro model: read data appears MEM_LAT cycles after the strobe
  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      pipe0[i] <= pipe0[i-1];
      pipe1[i] <= pipe1[i-1];
      pipe2[i] <= pipe2[i-1];
    end
    pipe0[0] <= (bus0.mem_en && !bus0.mem_we) ? mem_rd(bus0.mem_addr) : 16'hDEAD;
    pipe1[0] <= (bus1.mem_en && !bus1.mem_we) ? mem_rd(bus1.mem_addr) : 16'hDEAD;
    pipe2[0] <= (bus2.mem_en && !bus2.mem_we) ? mem_rd(bus2.mem_addr) : 16'hDEAD;
    if (bus0.mem_en && bus0.mem_we) mem_w[bus0.mem_addr] = bus0.mem_wdata;
  end

  // Scoreboard monitor on the MEM_LAT=2 instance
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0) begin
      if (bus0.gnt != 3'b000 || bus0.done != 3'b000) begin
        n_tests++;
        if (!$onehot0(bus0.gnt) || !$onehot0(bus0.done)) begin
          n_fail++;
          $display("FAIL onehot: gnt=%b done=%b, required at most one bit each", bus0.gnt, bus0.done);
        end
      end
      if (bus0.done != 3'b000) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_done: done=%b rdata=%h with nothing expected", bus0.done, bus0.rdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus0.done, bus0.rdata} !== {e.port, e.data}) begin
            n_fail++;
            $display("FAIL sb_done: got done=%b rdata=%h, required done=%b rdata=%h",
                     bus0.done, bus0.rdata, e.port, e.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    req = 3'b000;
    we  = 3'b000;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_rdata = 16'h0000;
    tick();
  endtask

  task automatic drain();
    req = 3'b000;
    for (int i = 0; i < 20 && bus0.busy !== 1'b0; i++) tick();
  endtask

  // One transaction on the MEM_LAT=2 instance with exact latency checks
  task automatic single_xact(input string name, input int p, input logic w,
                             input logic [15:0] a, input logic [15:0] d);
    logic [2:0]  oh;
    logic [15:0] exp_rd;
    logic [15:0] got_rd;
    int          lat;
    int          done_c;
    exp_t        e;
    oh     = 3'(1 << p);
    exp_rd = w ? model_rdata : mem_rd(a);
    e.port = oh;
    e.data = exp_rd;
    exp_q.push_back(e);
    model_rdata = exp_rd;
    lat = w ? 2 : 2 + LAT0;
    req = oh;
    we  = w ? oh : 3'b000;
    addr[p]  = a;
    wdata[p] = d;
    tick();
    n_tests++;
    if ({bus0.gnt, bus0.mem_en, bus0.mem_we, bus0.mem_addr, bus0.busy} !== {oh, 1'b1, w, a, 1'b1}) begin
      n_fail++;
      $display("FAIL %s_issue: got gnt=%b en=%b we=%b addr=%h busy=%b, required gnt=%b en=1 we=%b addr=%h busy=1",
               name, bus0.gnt, bus0.mem_en, bus0.mem_we, bus0.mem_addr, bus0.busy, oh, w, a);
    end
    if (w) begin
      n_tests++;
      if (bus0.mem_wdata !== d) begin
        n_fail++;
        $display("FAIL %s_wdata: got %h, required %h", name, bus0.mem_wdata, d);
      end
    end
    req = 3'b000;
    we  = 3'b000;
    done_c = -1;
    got_rd = 'x;
    for (int c = 2; c <= lat + 1; c++) begin
      tick();
      if (bus0.done != 3'b000 && done_c < 0) begin
        done_c = c;
        got_rd = bus0.rdata;
      end
    end
    n_tests++;
    if (done_c != lat) begin
      n_fail++;
      $display("FAIL %s_latency: done at t+%0d, required t+%0d", name, done_c, lat);
    end
    n_tests++;
    if (got_rd !== exp_rd) begin
      n_fail++;
      $display("FAIL %s_rdata: got %h, required %h", name, got_rd, exp_rd);
    end
    n_tests++;
    if (bus0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b after done, required 0", name, bus0.busy);
    end
  endtask

  // Hold the active requests, re-raise each after its done, check grant order
  task automatic run_seq(input string name, input logic [2:0] active,
                         input logic [2:0] seq [6], input int n);
    int   k;
    exp_t e;
    k = 0;
    we = 3'b000;
    for (int i = 0; i < n; i++) begin
      e.port = seq[i];
      e.data = mem_rd(addr[port_of(seq[i])]);
      exp_q.push_back(e);
      model_rdata = e.data;
    end
    req = active;
    for (int b = 0; b < 40 * n && k < n; b++) begin
      tick();
      if (bus0.gnt != 3'b000) begin
        n_tests++;
        if (bus0.gnt !== seq[k]) begin
          n_fail++;
          $display("FAIL %s_grant%0d: got %b, required %b", name, k, bus0.gnt, seq[k]);
        end
        req = req & ~bus0.gnt;
        k++;
      end
      if (bus0.done != 3'b000) req = req | (bus0.done & active);
    end
    if (k < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d grants, required %0d", name, k, n);
    end
    drain();
  endtask

  task automatic test_reset();
    req = 3'b000;
    we  = 3'b000;
    rst = 1'b1;
    tick(2);
    n_tests++;
    if ({bus0.gnt, bus0.done, bus0.mem_en, bus0.mem_we, bus0.busy} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got gnt=%b done=%b en=%b we=%b busy=%b, required all 0",
               bus0.gnt, bus0.done, bus0.mem_en, bus0.mem_we, bus0.busy);
    end
    n_tests++;
    if ({bus0.mem_addr, bus0.mem_wdata, bus0.rdata} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, required 0",
               bus0.mem_addr, bus0.mem_wdata, bus0.rdata);
    end
    rst = 1'b0;
    model_rdata = 16'h0000;
    tick(3);
    n_tests++;
    if ({bus0.busy, bus0.gnt} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b gnt=%b with no request, required 0", bus0.busy, bus0.gnt);
    end
  endtask

  task automatic test_fetch_read();
    single_xact("fetch_read", 2, 1'b0, 16'h0040, 16'h0000);
  endtask

  task automatic test_data_write();
    single_xact("data_write", 1, 1'b1, 16'h0123, 16'h5A5A);
    single_xact("dbg_readback", 0, 1'b0, 16'h0123, 16'h0000);
  endtask

  task automatic test_round_robin();
    do_reset();
    addr[1] = 16'h0010;
    addr[2] = 16'h0020;
    run_seq("rr", 3'b110, '{3'b100, 3'b010, 3'b100, 3'b010, 3'b000, 3'b000}, 4);
  endtask

  task automatic test_debug_priority();
    do_reset();
    addr[0] = 16'h0030;
    run_seq("dbg_mix", 3'b111, '{3'b001, 3'b100, 3'b001, 3'b010, 3'b001, 3'b100}, 6);
    run_seq("dbg_alone", 3'b001, '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000}, 2);
  endtask

  task automatic test_reset_mid();
    int late_done;
    req = 3'b100;
    we  = 3'b000;
    addr[2] = 16'h0050;
    tick();
    req = 3'b000;
    tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if ({bus0.busy, bus0.done, bus0.gnt, bus0.mem_en, bus0.rdata} !== 24'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got busy=%b done=%b gnt=%b en=%b rdata=%h, required all 0",
               bus0.busy, bus0.done, bus0.gnt, bus0.mem_en, bus0.rdata);
    end
    rst = 1'b0;
    model_rdata = 16'h0000;
    late_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus0.done != 3'b000) late_done++;
    end
    n_tests++;
    if (late_done != 0) begin
      n_fail++;
      $display("FAIL rst_mid_nodone: got %0d done pulses after reset, required 0", late_done);
    end
    single_xact("post_rst_read", 2, 1'b0, 16'h0040, 16'h0000);
  endtask

  task automatic test_latency();
    exp_t        e;
    int          c1, c2;
    logic [15:0] r1, r2;
    do_reset();
    e.port = 3'b100;
    e.data = mem_rd(16'h0040);
    exp_q.push_back(e);
    model_rdata = e.data;
    req = 3'b100;
    we  = 3'b000;
    addr[2] = 16'h0040;
    tick();
    n_tests++;
    if ({bus1.gnt, bus2.gnt} !== 6'b100_100) begin
      n_fail++;
      $display("FAIL lat_gnt: got gnt1=%b gnt2=%b, required 100 100", bus1.gnt, bus2.gnt);
    end
    req = 3'b000;
    c1 = -1;
    c2 = -1;
    r1 = 'x;
    r2 = 'x;
    for (int c = 2; c <= 14; c++) begin
      tick();
      if (bus1.done[2] && c1 < 0) begin c1 = c; r1 = bus1.rdata; end
      if (bus2.done[2] && c2 < 0) begin c2 = c; r2 = bus2.rdata; end
    end
    n_tests++;
    if (c1 != 2 + LAT1 || r1 !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL lat1: done at t+%0d rdata=%h, required t+%0d rdata=beef", c1, r1, 2 + LAT1);
    end
    n_tests++;
    if (c2 != 2 + LAT2 || r2 !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL lat7: done at t+%0d rdata=%h, required t+%0d rdata=beef", c2, r2, 2 + LAT2);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000;
    we  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr[i]  = 16'h0000;
      wdata[i] = 16'h0000;
    end
    model_rdata = 16'h0000;

    test_reset();
    test_fetch_read();
    test_data_write();
    test_round_robin();
    test_debug_priority();
    test_reset_mid();
    test_latency();

    tick(2);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected completions never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
